// File: rtl/apu_audio_pwm_if.sv
// AHB-Lite slave bus bundle for the APU audio output peripheral.
interface apu_audio_pwm_if;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic        hready_resp;
  logic        hresp;
  logic [31:0] hwdata;
  logic [31:0] hrdata;

  modport master (
    output haddr, htrans, hwrite, hsize, hready, hwdata,
    input  hready_resp, hresp, hrdata
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hready, hwdata,
    output hready_resp, hresp, hrdata
  );
endinterface

// File: rtl/apu_audio_pwm.sv
// APU audio peripheral: AHB-Lite CSRs, frame FIFO, sample-rate divider and per-channel PWM.
// Defining APU_AUDIO_SDM_EN adds a first-order sigma-delta output mode selected by CSR.MODE.
module apu_audio_pwm #(
  parameter int N_CHAN     = 2,
  parameter int W_SAMPLE   = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int W_DIV      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  apu_audio_pwm_if.slave    ahbls,
  output logic              irq,
  output logic [N_CHAN-1:0] audio_out
);
  localparam int FW = N_CHAN * W_SAMPLE;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  logic                act_q, wr_q;
  logic [1:0]          addr_q;
  logic                en_q, irq_en_q, underrun_q, overrun_q, mode;
  logic [W_DIV-1:0]    div_q, divcnt_q;
  logic [7:0]          thresh_q;
  logic [W_SAMPLE-1:0] ctr_q;
  logic [FW-1:0]       fifo_q [FIFO_DEPTH];
  logic [AW-1:0]       rptr_q, wptr_q;
  logic [LW-1:0]       level_q;
  logic [FW-1:0]       cur_q;
  logic [N_CHAN-1:0]   out_d, audio_q;
  logic                irq_q;
  logic [31:0]         rdata;

  logic wr_csr, wr_div, wr_fifo, wr_thr, flush;
  logic tick, sample_tick, fifo_empty, fifo_full, pop, push;
  logic overrun_set, underrun_set;
  logic unused_bits;

  // Address phase is latched; the following cycle is the (zero-wait) data phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= 2'd0;
    end else begin
      act_q <= ahbls.hready && ahbls.htrans[1];
      if (ahbls.hready && ahbls.htrans[1]) begin
        wr_q   <= ahbls.hwrite;
        addr_q <= ahbls.haddr[3:2];
      end
    end
  end

  assign wr_csr  = act_q && wr_q && (addr_q == 2'd0);
  assign wr_div  = act_q && wr_q && (addr_q == 2'd1);
  assign wr_fifo = act_q && wr_q && (addr_q == 2'd2);
  assign wr_thr  = act_q && wr_q && (addr_q == 2'd3);
  assign flush   = wr_csr && ahbls.hwdata[1];

  assign fifo_empty   = (level_q == '0);
  assign fifo_full    = (level_q == LEVEL_FULL);
  assign tick         = en_q && (ctr_q == '1);
  assign sample_tick  = tick && (divcnt_q == '0);
  assign pop          = sample_tick && !fifo_empty && !flush;
  assign push         = wr_fifo && !flush && (!fifo_full || pop);
  assign overrun_set  = wr_fifo && !flush && fifo_full && !pop;
  assign underrun_set = sample_tick && fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      div_q      <= '0;
      thresh_q   <= '0;
    end else begin
      if (wr_csr) begin
        en_q     <= ahbls.hwdata[0];
        irq_en_q <= ahbls.hwdata[2];
      end
      if (wr_div) div_q <= ahbls.hwdata[W_DIV-1:0];
      if (wr_thr) thresh_q <= ahbls.hwdata[7:0];
      // A new event wins over a simultaneous write-1-to-clear.
      if (underrun_set)                      underrun_q <= 1'b1;
      else if (wr_csr && ahbls.hwdata[8])    underrun_q <= 1'b0;
      if (overrun_set)                       overrun_q  <= 1'b1;
      else if (wr_csr && ahbls.hwdata[9])    overrun_q  <= 1'b0;
    end
  end

`ifdef APU_AUDIO_SDM_EN
  logic mode_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mode_q <= 1'b0;
    else if (wr_csr) mode_q <= ahbls.hwdata[3];
  end
  assign mode = mode_q;
`else
  assign mode = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= ahbls.hwdata[FW-1:0];
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  // Sample timing: divider advances once per PWM period; all of it parks at 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q    <= '0;
      divcnt_q <= '0;
      cur_q    <= '0;
    end else if (!en_q) begin
      ctr_q    <= '0;
      divcnt_q <= '0;
      cur_q    <= '0;
    end else begin
      ctr_q <= ctr_q + 1'b1;
      if (tick) divcnt_q <= (divcnt_q == '0) ? div_q : divcnt_q - 1'b1;
      if (pop)  cur_q <= fifo_q[rptr_q];
    end
  end

  for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
    logic [W_SAMPLE-1:0] cur_ch;
    logic                pwm_bit;
    assign cur_ch  = cur_q[gi*W_SAMPLE +: W_SAMPLE];
    assign pwm_bit = (ctr_q < cur_ch);
`ifdef APU_AUDIO_SDM_EN
    logic [W_SAMPLE-1:0] acc_q;
    logic [W_SAMPLE:0]   acc_d;
    assign acc_d = {1'b0, acc_q} + {1'b0, cur_ch};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= en_q ? acc_d[W_SAMPLE-1:0] : '0;
    end
    assign out_d[gi] = mode ? acc_d[W_SAMPLE] : pwm_bit;
`else
    assign out_d[gi] = pwm_bit;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      audio_q <= en_q ? out_d : '0;
      irq_q   <= irq_en_q && ((en_q && (8'(level_q) <= thresh_q)) || underrun_q);
    end
  end

  always_comb begin
    rdata = '0;
    if (act_q && !wr_q) begin
      case (addr_q)
        2'd0:    rdata = {8'h00, 8'(level_q), 6'h00, overrun_q, underrun_q,
                          4'h0, mode, irq_en_q, 1'b0, en_q};
        2'd1:    rdata = 32'(div_q);
        2'd3:    rdata = {24'h0, thresh_q};
        default: rdata = '0;
      endcase
    end
  end

  assign ahbls.hrdata      = rdata;
  assign ahbls.hready_resp = 1'b1;
  assign ahbls.hresp       = 1'b0;
  assign audio_out         = audio_q;
  assign irq               = irq_q;

  assign unused_bits = ^{ahbls.hsize, ahbls.haddr[15:4], ahbls.haddr[1:0],
                         ahbls.htrans[0], ahbls.hwdata};
endmodule

// File: tb/tb_apu_audio_pwm.sv
// Scoreboard bench for apu_audio_pwm: expected frame duties and register values are queued
// as stimulus is driven and checked when the DUT emits them.
module tb_apu_audio_pwm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       irq;
  logic [1:0] audio_out;

  apu_audio_pwm_if bus ();

  apu_audio_pwm #(
    .N_CHAN(2), .W_SAMPLE(8), .FIFO_DEPTH(8), .W_DIV(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ahbls(bus),
    .irq(irq),
    .audio_out(audio_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h0;
    int h1;
  } duty_t;

  duty_t       sb_q[$];
  logic [31:0] rd_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic bus_idle();
    bus.haddr  = 16'h0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd2;
    bus.hready = 1'b1;
    bus.hwdata = 32'h0;
  endtask

  // Returns on the negedge right after the write has taken effect.
  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.haddr = {12'h0, a}; bus.htrans = 2'b10; bus.hwrite = 1'b1;
    @(negedge clk);
    bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = d;
    @(negedge clk);
    $display("wr  addr=%h data=%h", a, d);
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.haddr = {12'h0, a}; bus.htrans = 2'b10; bus.hwrite = 1'b0;
    @(negedge clk);
    bus.htrans = 2'b00;
    d = bus.hrdata;
    $display("rd  addr=%h data=%h", a, d);
  endtask

  task automatic do_reset();
    bus_idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      h0 += int'(audio_out[0]);
      h1 += int'(audio_out[1]);
    end
  endtask

  task automatic test_reset(input string tag);
    logic [31:0] v, e;
    bus_idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (audio_out !== 2'b00) begin bad++; $display("FAIL %s_audio got=%b exp=00", tag, audio_out); end
    else $display("ok  %s_audio", tag);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL %s_irq got=%b exp=0", tag, irq); end
    else $display("ok  %s_irq", tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.hready_resp !== 1'b1 || bus.hresp !== 1'b0) begin
      bad++; $display("FAIL %s_resp got=%b/%b exp=1/0", tag, bus.hready_resp, bus.hresp);
    end else $display("ok  %s_resp", tag);
    for (int a = 0; a < 4; a++) begin
      rd_q.push_back(32'h0);
      ahb_read(4'(a * 4), v);
      e = rd_q.pop_front();
      total++;
      if (v !== e) begin bad++; $display("FAIL %s_reg%0d got=%h exp=%h", tag, a, v, e); end
      else $display("ok  %s_reg%0d", tag, a);
    end
  endtask

  task automatic test_regs();
    logic [31:0] v, e;
    do_reset();
    ahb_write(4'h4, 32'hFFFF_FABC);
    rd_q.push_back(32'h0000_0ABC);
    ahb_read(4'h4, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL div_rb got=%h exp=%h", v, e); end
    else $display("ok  div_rb");
    ahb_write(4'hC, 32'h0000_1234);
    rd_q.push_back(32'h0000_0034);
    ahb_read(4'hC, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL thresh_rb got=%h exp=%h", v, e); end
    else $display("ok  thresh_rb");
    ahb_write(4'h0, 32'h0000_0004);
    rd_q.push_back(32'h0000_0004);
    ahb_read(4'h0, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL csr_rb got=%h exp=%h", v, e); end
    else $display("ok  csr_rb");
  endtask

  task automatic test_pwm();
    duty_t d;
    int    h0, h1;
    do_reset();
    d.h0 = 192; d.h1 = 64;
    sb_q.push_back(d);
    sb_q.push_back(d);
    ahb_write(4'h8, 32'h0000_40C0);
    ahb_write(4'h0, 32'h0000_0001);
    measure(h0, h1);
    total++;
    if (h0 !== 0 || h1 !== 0) begin bad++; $display("FAIL pwm_pre_tick got=%0d/%0d exp=0/0", h0, h1); end
    else $display("ok  pwm_pre_tick");
    for (int k = 0; k < 2; k++) begin
      measure(h0, h1);
      d = sb_q.pop_front();
      total++;
      if (h0 !== d.h0 || h1 !== d.h1) begin
        bad++; $display("FAIL pwm_period%0d got=%0d/%0d exp=%0d/%0d", k, h0, h1, d.h0, d.h1);
      end else $display("ok  pwm_period%0d %0d/%0d", k, h0, h1);
    end
  endtask

  task automatic test_overrun();
    duty_t       d;
    logic [31:0] v, e;
    logic [7:0]  c0 [9];
    logic [7:0]  c1;
    int          h0, h1;
    c0 = '{8'hFF, 8'h00, 8'h01, 8'h80, 8'h10, 8'h20, 8'h30, 8'h40, 8'hEE};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      c1 = 8'(k * 16 + 3);
      if (k < 8) begin
        d.h0 = int'(c0[k]); d.h1 = int'(c1);
        sb_q.push_back(d);
      end
      ahb_write(4'h8, {16'h0, c1, c0[k]});
    end
    d.h0 = 8'h40; d.h1 = 8'h73;
    sb_q.push_back(d);
    rd_q.push_back(32'h0008_0200);
    ahb_read(4'h0, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL ovr_csr got=%h exp=%h", v, e); end
    else $display("ok  ovr_csr");
    ahb_write(4'h0, 32'h0000_0001);
    measure(h0, h1);
    for (int k = 0; k < 9; k++) begin
      measure(h0, h1);
      d = sb_q.pop_front();
      total++;
      if (h0 !== d.h0 || h1 !== d.h1) begin
        bad++; $display("FAIL ovr_frame%0d got=%0d/%0d exp=%0d/%0d", k, h0, h1, d.h0, d.h1);
      end else $display("ok  ovr_frame%0d %0d/%0d", k, h0, h1);
    end
    rd_q.push_back(32'h0000_0301);
    ahb_read(4'h0, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL ovr_csr_end got=%h exp=%h", v, e); end
    else $display("ok  ovr_csr_end");
  endtask

  task automatic test_underrun();
    duty_t       d;
    logic [31:0] v, e;
    int          h0, h1;
    do_reset();
    ahb_write(4'h4, 32'h0000_0001);
    d.h0 = 8'h20; d.h1 = 8'hE0;
    sb_q.push_back(d); sb_q.push_back(d);
    ahb_write(4'h8, 32'h0000_E020);
    d.h0 = 8'hA0; d.h1 = 8'h05;
    sb_q.push_back(d); sb_q.push_back(d); sb_q.push_back(d);
    ahb_write(4'h8, 32'h0000_05A0);
    ahb_write(4'h0, 32'h0000_0001);
    measure(h0, h1);
    for (int k = 0; k < 5; k++) begin
      measure(h0, h1);
      d = sb_q.pop_front();
      total++;
      if (h0 !== d.h0 || h1 !== d.h1) begin
        bad++; $display("FAIL div_window%0d got=%0d/%0d exp=%0d/%0d", k, h0, h1, d.h0, d.h1);
      end else $display("ok  div_window%0d %0d/%0d", k, h0, h1);
    end
    rd_q.push_back(32'h0000_0101);
    ahb_read(4'h0, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL udr_set got=%h exp=%h", v, e); end
    else $display("ok  udr_set");
    ahb_write(4'h0, 32'h0000_0101);
    rd_q.push_back(32'h0000_0001);
    ahb_read(4'h0, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL udr_w1c got=%h exp=%h", v, e); end
    else $display("ok  udr_w1c");
  endtask

  task automatic test_irq();
    logic [31:0] v, e;
    int          h0, h1;
    do_reset();
    for (int k = 0; k < 4; k++) ahb_write(4'h8, 32'h0000_8080);
    ahb_write(4'hC, 32'h0000_0002);
    ahb_write(4'h0, 32'h0000_0004);
    wait_cycles(2);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_disabled got=%b exp=0", irq); end
    else $display("ok  irq_disabled");
    ahb_write(4'h0, 32'h0000_0005);
    wait_cycles(300);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_level3 got=%b exp=0", irq); end
    else $display("ok  irq_level3");
    wait_cycles(220);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_level2 got=%b exp=1", irq); end
    else $display("ok  irq_level2");
    rd_q.push_back(32'h0002_0005);
    ahb_read(4'h0, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL irq_csr got=%h exp=%h", v, e); end
    else $display("ok  irq_csr");
    ahb_write(4'h8, 32'h0000_8080);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_registered got=%b exp=1", irq); end
    else $display("ok  irq_registered");
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_push_clear got=%b exp=0", irq); end
    else $display("ok  irq_push_clear");
    ahb_write(4'h0, 32'h0000_0004);
    @(negedge clk);
    measure(h0, h1);
    total++;
    if (h0 !== 0 || h1 !== 0 || irq !== 1'b0) begin
      bad++; $display("FAIL disable_quiet got=%0d/%0d irq=%b exp=0/0 irq=0", h0, h1, irq);
    end else $display("ok  disable_quiet");
    rd_q.push_back(32'h0003_0004);
    ahb_read(4'h0, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL disable_retain got=%h exp=%h", v, e); end
    else $display("ok  disable_retain");
    ahb_write(4'h0, 32'h0000_0006);
    rd_q.push_back(32'h0000_0004);
    ahb_read(4'h0, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL flush got=%h exp=%h", v, e); end
    else $display("ok  flush");
  endtask

  task automatic test_mode();
    logic [31:0] v, e;
    do_reset();
    ahb_write(4'h0, 32'h0000_0008);
`ifdef APU_AUDIO_SDM_EN
    rd_q.push_back(32'h0000_0008);
`else
    rd_q.push_back(32'h0000_0000);
`endif
    ahb_read(4'h0, v); e = rd_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL mode_rb got=%h exp=%h", v, e); end
    else $display("ok  mode_rb");
`ifdef APU_AUDIO_SDM_EN
    begin
      int         toggles;
      logic [1:0] prev;
      ahb_write(4'h8, 32'h0000_8080);
      ahb_write(4'h0, 32'h0000_0009);
      wait_cycles(260);
      toggles = 0;
      prev = audio_out;
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        if (audio_out === ~prev) toggles++;
        prev = audio_out;
      end
      total++;
      if (toggles !== 32) begin bad++; $display("FAIL sdm_toggle got=%0d exp=32", toggles); end
      else $display("ok  sdm_toggle");
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    test_reset("reset");
    test_regs();
    test_pwm();
    test_overrun();
    test_underrun();
    test_irq();
    test_mode();
    ahb_write(4'h8, 32'h0000_1111);
    ahb_write(4'h8, 32'h0000_2222);
    test_reset("midreset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
